// File: rtl/unified_memory_responder_pkg.sv
// Shared types and I/O window offsets for the unified memory responder.
package unified_memory_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam logic [31:0] IO_OUT_OFS = 32'd0;
  localparam logic [31:0] IO_CNT_OFS = 32'd4;

endpackage

// File: rtl/unified_memory_responder_if.sv
// CPU fetch/data bus plus boot-load port and I/O outputs of the responder.
interface unified_memory_responder_if;
  logic [31:0] address;
  logic [31:0] readData;
  logic [31:0] address2;
  logic        memRead2;
  logic        memWrite;
  logic [31:0] writeData;
  logic [31:0] readData2;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadLast;
  logic        loadReady;
  logic        cpuReset;
  logic [31:0] ioOut;
  logic        ioStrobe;
  logic        errFlag;

  modport master (
    output address, address2, memRead2, memWrite, writeData,
    output loadValid, loadData, loadLast,
    input  readData, readData2, loadReady, cpuReset, ioOut, ioStrobe, errFlag
  );

  modport slave (
    input  address, address2, memRead2, memWrite, writeData,
    input  loadValid, loadData, loadLast,
    output readData, readData2, loadReady, cpuReset, ioOut, ioStrobe, errFlag
  );
endinterface

// File: rtl/unified_memory_responder_mem_boot_loader.sv
// Boot-load sequencer: fills the array word by word while holding the CPU in
// reset, then gives the CPU one reset cycle (RELEASE) before letting it run.
module mem_boot_loader
  import unified_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_valid_i,
  input  logic          load_last_i,
  output logic          load_ready_o,
  output logic          load_write_o,
  output logic [AW-1:0] load_addr_o,
  output logic          cpu_reset_o,
  output logic          run_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_ready_o = 1'b0;
    load_write_o = 1'b0;
    cpu_reset_o  = 1'b1;
    run_o        = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          load_write_o = 1'b1;
          // The last slot ends the load without advancing, so ptr never wraps.
          if (load_last_i || ptr_q == AW'(DEPTH_WORDS - 1)) begin
            state_d = RELEASE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      RELEASE: state_d = RUN;
      RUN: begin
        cpu_reset_o = 1'b0;
        run_o       = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  assign load_addr_o = ptr_q;

endmodule

// File: rtl/unified_memory_responder.sv
// Single-port-per-side word array serving fetch and data access with zero wait
// states, boot-loaded via valid/ready, with a small memory-mapped I/O window.
module unified_memory_responder
  import unified_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
  input logic                        clock,
  input logic                        reset,
  unified_memory_responder_if.slave  bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic          load_write, run;
  logic [AW-1:0] load_addr;

  logic [31:0] io_out_q, io_out_d;
  logic        io_strobe_q, io_strobe_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        err_q, err_d;

  mem_boot_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_boot (
    .clk_i        (clock),
    .rst_i        (reset),
    .load_valid_i (bus.loadValid),
    .load_last_i  (bus.loadLast),
    .load_ready_o (bus.loadReady),
    .load_write_o (load_write),
    .load_addr_o  (load_addr),
    .cpu_reset_o  (bus.cpuReset),
    .run_o        (run)
  );

  logic [AW-1:0] fetch_idx, data_idx;
  logic          fetch_in_range, data_in_range, data_io, io_out_sel, io_cnt_sel;
  logic          data_misaligned, data_wr, data_rd, bad_access;

  assign fetch_idx       = bus.address[AW+1:2];
  assign data_idx        = bus.address2[AW+1:2];
  assign fetch_in_range  = bus.address < MEM_BYTES;
  assign data_in_range   = bus.address2 < MEM_BYTES;
  assign data_io         = bus.address2[31:4] == IO_BASE[31:4];
  // I/O registers decode on the word index so misaligned accesses still land.
  assign io_out_sel      = data_io && bus.address2[3:2] == IO_OUT_OFS[3:2];
  assign io_cnt_sel      = data_io && bus.address2[3:2] == IO_CNT_OFS[3:2];
  assign data_misaligned = bus.address2[1:0] != 2'b00;
  assign data_wr         = run && bus.memWrite;
  assign data_rd         = run && bus.memRead2;

  always_comb begin
    bus.readData = '0;
    if (run && fetch_in_range) bus.readData = mem[fetch_idx];
    bus.readData2 = '0;
    if (data_rd) begin
      if (data_in_range)   bus.readData2 = mem[data_idx];
      else if (io_out_sel) bus.readData2 = io_out_q;
      else if (io_cnt_sel) bus.readData2 = cyc_cnt_q;
    end
  end

  always_comb begin
    bad_access = 1'b0;
    if (run && !fetch_in_range) bad_access = 1'b1;
    if (data_rd && !(data_in_range || io_out_sel || io_cnt_sel)) bad_access = 1'b1;
    if (data_wr && !(data_in_range || io_out_sel)) bad_access = 1'b1;
    if ((data_rd || data_wr) && data_misaligned) bad_access = 1'b1;
    err_d       = err_q | bad_access;
    io_strobe_d = data_wr && io_out_sel;
    io_out_d    = io_strobe_d ? bus.writeData : io_out_q;
    cyc_cnt_d   = run ? cyc_cnt_q + 32'd1 : cyc_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
      cyc_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      cyc_cnt_q   <= cyc_cnt_d;
      err_q       <= err_d;
    end
  end

  // Array survives reset so a warm restart keeps previously loaded words.
  always_ff @(posedge clock) begin
    if (load_write) begin
      mem[load_addr] <= bus.loadData;
    end else if (data_wr && data_in_range) begin
      mem[data_idx] <= bus.writeData;
    end
  end

  assign bus.ioOut    = io_out_q;
  assign bus.ioStrobe = io_strobe_q;
  assign bus.errFlag  = err_q;

endmodule

// File: tb/tb_unified_memory_responder.sv
// Directed plus randomized bench for unified_memory_responder with a per-cycle
// behavioural model of the array, load sequence, I/O window and error flag.
module tb_unified_memory_responder;

  localparam int          D   = 64;
  localparam int          AW  = 6;
  localparam int          MB  = 4 * D;
  localparam logic [31:0] IOB = 32'hFFFF_FF00;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unified_memory_responder_if bus();

  unified_memory_responder #(.DEPTH_WORDS(D), .IO_BASE(IOB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Model: phase 0 = loading, 1 = one-cycle CPU reset release, 2 = running.
  logic [31:0] mm [D];
  int          phase = 0;
  int          ptr   = 0;
  logic [31:0] m_io  = '0;
  logic [31:0] m_cyc = '0;
  logic        m_strobe = 1'b0;
  logic        m_err    = 1'b0;
  bit          started  = 1'b0;

  logic [31:0] w1 [4];
  logic [31:0] w2 [D];
  logic [31:0] x0, x1, y0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit io_word(logic [31:0] a, logic [1:0] w);
    return a[31:4] == IOB[31:4] && a[3:2] == w;
  endfunction

  function automatic logic [31:0] exp_fetch(logic [31:0] a);
    if (phase != 2 || a >= 32'(MB)) return '0;
    return mm[a[AW+1:2]];
  endfunction

  function automatic logic [31:0] exp_data(logic [31:0] a, logic rd);
    if (phase != 2 || !rd) return '0;
    if (a < 32'(MB)) return mm[a[AW+1:2]];
    if (io_word(a, 2'd0)) return m_io;
    if (io_word(a, 2'd1)) return m_cyc;
    return '0;
  endfunction

  task automatic check_all();
    chk("cpuReset",  32'(bus.cpuReset),  32'(phase != 2));
    chk("loadReady", 32'(bus.loadReady), 32'(phase == 0));
    chk("readData",  bus.readData,  exp_fetch(bus.address));
    chk("readData2", bus.readData2, exp_data(bus.address2, bus.memRead2));
    chk("ioOut",     bus.ioOut,     m_io);
    chk("ioStrobe",  32'(bus.ioStrobe), 32'(m_strobe));
    chk("errFlag",   32'(bus.errFlag),  32'(m_err));
  endtask

  task automatic model_edge();
    logic [31:0] a2;
    bit bad;
    a2 = bus.address2;
    if (reset) begin
      phase = 0; ptr = 0; m_io = '0; m_cyc = '0; m_strobe = 1'b0; m_err = 1'b0;
      started = 1'b1;
    end else if (phase == 0) begin
      m_strobe = 1'b0;
      if (bus.loadValid) begin
        mm[ptr] = bus.loadData;
        if (bus.loadLast || ptr == D - 1) phase = 1;
        else ptr++;
      end
    end else if (phase == 1) begin
      phase = 2;
    end else begin
      bad = bus.address >= 32'(MB);
      if (bus.memRead2 && !(a2 < 32'(MB) || io_word(a2, 2'd0) || io_word(a2, 2'd1))) bad = 1;
      if ((bus.memRead2 || bus.memWrite) && a2[1:0] != 2'b00) bad = 1;
      m_strobe = 1'b0;
      if (bus.memWrite) begin
        if (a2 < 32'(MB)) mm[a2[AW+1:2]] = bus.writeData;
        else if (io_word(a2, 2'd0)) begin
          m_io = bus.writeData;
          m_strobe = 1'b1;
        end else bad = 1;
      end
      if (bad) m_err = 1'b1;
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic tick();
    #1;
    if (started) check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.address = '0; bus.address2 = '0; bus.memRead2 = 0; bus.memWrite = 0;
    bus.writeData = '0; bus.loadValid = 0; bus.loadData = '0; bus.loadLast = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_cpuReset", 32'(bus.cpuReset), 32'd1);
    chk("rst_loadReady", 32'(bus.loadReady), 32'd1);
    chk("rst_ioOut", bus.ioOut, 32'd0);
    chk("rst_ioStrobe", 32'(bus.ioStrobe), 32'd0);
    chk("rst_errFlag", 32'(bus.errFlag), 32'd0);

    // Short load ending on loadLast.
    for (int i = 0; i < 4; i++) begin
      w1[i] = $urandom;
      bus.loadValid = 1; bus.loadData = w1[i]; bus.loadLast = (i == 3);
      #1 chk("t1_loading_cpuReset", 32'(bus.cpuReset), 32'd1);
      tick();
    end
    idle();
    #1;
    chk("t1_release_cpuReset", 32'(bus.cpuReset), 32'd1);
    chk("t1_release_loadReady", 32'(bus.loadReady), 32'd0);
    tick();
    bus.address = 32'd8;
    #1;
    chk("t1_run_cpuReset", 32'(bus.cpuReset), 32'd0);
    chk("t1_fetch8", bus.readData, w1[2]);
    tick();

    // Full load with gaps and no loadLast.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    for (int i = 0; i < D; i++) w2[i] = $urandom;
    n = 0;
    for (int c = 0; c < 4 * D && n < D; c++) begin
      bus.loadValid = ($urandom_range(0, 3) != 0);
      bus.loadData = w2[n];
      bus.loadLast = 0;
      #1;
      if (bus.loadValid) n++;
      tick();
    end
    chk("t2_handshakes", 32'(n), 32'(D));
    bus.loadValid = 1; bus.loadData = 32'h0BAD_0BAD;
    #1;
    chk("t2_release_loadReady", 32'(bus.loadReady), 32'd0);
    chk("t2_release_cpuReset", 32'(bus.cpuReset), 32'd1);
    tick();
    tick();
    idle();
    #1 chk("t2_word0_no_wrap", bus.readData, w2[0]);
    bus.address = 32'(4 * (D - 1));
    #1 chk("t2_last_word", bus.readData, w2[D-1]);
    tick();

    // Read-during-write on the same word.
    bus.address = 32'h10; bus.address2 = 32'h10; bus.memRead2 = 1;
    bus.memWrite = 1; bus.writeData = 32'hDEAD_BEEF;
    #1;
    chk("t3_fetch_old", bus.readData, w2[4]);
    chk("t3_read2_old", bus.readData2, w2[4]);
    tick();
    idle(); bus.address = 32'h10;
    #1 chk("t3_fetch_new", bus.readData, 32'hDEAD_BEEF);
    tick();

    // I/O output register and cycle counter.
    bus.address2 = IOB; bus.memWrite = 1; bus.writeData = 32'h5A;
    #1 chk("t4_strobe_before", 32'(bus.ioStrobe), 32'd0);
    tick();
    idle();
    #1;
    chk("t4_ioOut", bus.ioOut, 32'h5A);
    chk("t4_strobe_pulse", 32'(bus.ioStrobe), 32'd1);
    tick();
    bus.address2 = IOB + 32'd4; bus.memRead2 = 1;
    #1;
    chk("t4_strobe_after", 32'(bus.ioStrobe), 32'd0);
    chk("t4_cycCnt", bus.readData2, m_cyc);
    chk("t4_no_err", 32'(bus.errFlag), 32'd0);
    tick();

    // Out-of-range write is dropped and latches the error flag.
    idle(); bus.address2 = 32'(MB); bus.memWrite = 1; bus.writeData = 32'h1234_5678;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_err_held", 32'(bus.errFlag), 32'd1);
      chk("t5_word0_kept", bus.readData, w2[0]);
      tick();
    end

    // Randomized run traffic against the model.
    for (int c = 0; c < 200; c++) begin
      case ($urandom_range(0, 3))
        0, 1: bus.address2 = 32'($urandom_range(0, D - 1)) << 2;
        2:    bus.address2 = IOB + (32'($urandom_range(0, 2)) << 2);
        default: bus.address2 = $urandom;
      endcase
      bus.address = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, D - 1)) << 2;
      bus.memRead2 = $urandom_range(0, 1);
      bus.memWrite = ($urandom_range(0, 2) == 0);
      bus.writeData = $urandom;
      bus.loadValid = $urandom_range(0, 1);
      bus.loadData = $urandom;
      tick();
    end
    idle();

    // Reset in the middle of a load keeps the array and restarts at word 0.
    reset = 1'b1; tick(); reset = 1'b0;
    x0 = $urandom; x1 = $urandom; y0 = $urandom;
    bus.loadValid = 1; bus.loadData = x0; tick();
    bus.loadData = x1; tick();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    #1;
    chk("t6_cpuReset", 32'(bus.cpuReset), 32'd1);
    chk("t6_loadReady", 32'(bus.loadReady), 32'd1);
    bus.loadValid = 1; bus.loadData = y0; bus.loadLast = 1;
    tick();
    idle();
    tick();
    #1 chk("t6_word0_reloaded", bus.readData, y0);
    bus.address = 32'd4;
    #1 chk("t6_word1_retained", bus.readData, x1);
    bus.address = 32'd8;
    #1 chk("t6_word2_retained", bus.readData, mm[2]);
    tick();

    // Misaligned data read uses the word index and flags an error.
    idle(); bus.address2 = 32'h3; bus.memRead2 = 1;
    #1;
    chk("t5_misalign_err_before", 32'(bus.errFlag), 32'd0);
    chk("t5_misalign_data", bus.readData2, y0);
    tick();
    idle();
    #1 chk("t5_misalign_err", 32'(bus.errFlag), 32'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
